// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enum, default width and opcode validity helper for the alu
package alu_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
    OP_SRA = 4'd8, OP_ROL = 4'd9, OP_ROR = 4'd10, OP_MUL = 4'd11,
    OP_DIV = 4'd12, OP_MOD = 4'd13
  } op_e;
  function automatic logic is_valid_op(op_e op);
    return op <= OP_MOD;
  endfunction
endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: combinational next result, carry and error from operands and opcode
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             error
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     sum, diff, shl, shr, sra;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rol, ror, quo, rem, res;
  logic               c, div_zero;
  assign sh       = b[SW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  // shifts carry one extra bit so the last bit shifted out lands in the flag
  assign shl      = {1'b0, a} << sh;
  assign shr      = {a, 1'b0} >> sh;
  assign sra      = $signed({a, 1'b0}) >>> sh;
  assign rol      = (a << sh) | (a >> (WIDTH - int'(sh)));
  assign ror      = (a >> sh) | (a << (WIDTH - int'(sh)));
  assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign quo      = (b == '0) ? '0 : a / b;
  assign rem      = (b == '0) ? '0 : a % b;
  assign div_zero = (op_e'(op) == OP_DIV || op_e'(op) == OP_MOD) && b == '0;
  always_comb begin
    res = '0;
    c   = 1'b0;
    case (op_e'(op))
      OP_ADD: {c, res} = sum;
      OP_SUB: {c, res} = diff;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: {c, res} = shl;
      OP_SHR: {res, c} = shr;
      OP_SRA: {res, c} = sra;
      OP_ROL: res = rol;
      OP_ROR: res = ror;
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        c   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: res = quo;
      OP_MOD: res = rem;
      default: res = '0;
    endcase
  end
  assign error  = !is_valid_op(op_e'(op)) || div_zero;
  assign result = error ? '0 : res;
  assign carry  = error ? 1'b0 : c;
endmodule

// File: rtl/alu_core.sv
// alu_core: registered single-cycle alu with zero, carry and error flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             error_o
);
  logic [WIDTH-1:0] r;
  logic             c, e;
  alu_datapath #(.WIDTH(WIDTH)) u_dp (
    .a(a_i), .b(b_i), .op(op_i), .result(r), .carry(c), .error(e)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result_o <= '0;
      zero_o   <= 1'b0;
      carry_o  <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      result_o <= r;
      zero_o   <= !e && r == '0;
      carry_o  <= c;
      error_o  <= e;
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core, directed vectors plus a short random run
module tb_alu_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [3:0] op = '0;
  logic [7:0] result;
  logic       zero, carry, error;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] r;
    logic       z, c, e;
    string      name;
  } exp_t;
  exp_t q[$];
  alu_core #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a_i(a), .b_i(b), .op_i(op),
    .result_o(result), .zero_o(zero), .carry_o(carry), .error_o(error)
  );
  always #5 clk = ~clk;
  task automatic compare(input exp_t x);
    checks++;
    if ({result, zero, carry, error} !== {x.r, x.z, x.c, x.e}) begin
      errors++;
      $display("FAIL %s: got r=%h z=%b c=%b e=%b, expected r=%h z=%b c=%b e=%b",
               x.name, result, zero, carry, error, x.r, x.z, x.c, x.e);
    end
  endtask
  function automatic exp_t model(input logic [7:0] av, bv, input logic [3:0] ov);
    int unsigned ai = av, bi = bv, sh = bv & 7, t = 0, c = 0;
    logic e = 1'b0;
    exp_t x;
    case (ov)
      0: begin t = ai + bi; c = t >> 8; end
      1: begin t = 256 + ai - bi; c = (ai < bi) ? 1 : 0; end
      2: t = ai & bi;
      3: t = ai | bi;
      4: t = ai ^ bi;
      5: t = ~ai;
      6: begin t = ai << sh; c = sh != 0 ? (ai >> (8 - sh)) & 1 : 0; end
      7: begin t = ai >> sh; c = sh != 0 ? (ai >> (sh - 1)) & 1 : 0; end
      8: begin
        t = (ai >> sh) | (av[7] ? (255 << (8 - sh)) : 0);
        c = sh != 0 ? (ai >> (sh - 1)) & 1 : 0;
      end
      9:  t = (ai << sh) | (ai >> (8 - sh));
      10: t = (ai >> sh) | (ai << (8 - sh));
      11: begin t = ai * bi; c = t > 255 ? 1 : 0; end
      12: if (bi == 0) e = 1'b1; else t = ai / bi;
      13: if (bi == 0) e = 1'b1; else t = ai % bi;
      default: e = 1'b1;
    endcase
    x.e = e;
    x.r = e ? 8'h00 : 8'(t & 255);
    x.c = e ? 1'b0 : c[0];
    x.z = !e && x.r == 8'h00;
    x.name = $sformatf("model op=%0d a=%h b=%h", ov, av, bv);
    return x;
  endfunction
  task automatic issue(input logic [7:0] av, bv, input logic [3:0] ov,
                       input logic [7:0] r, input logic z, c, e, input string name);
    exp_t x;
    @(negedge clk);
    a = av; b = bv; op = ov;
    x.r = r; x.z = z; x.c = c; x.e = e; x.name = name;
    q.push_back(x);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() != 0) compare(q.pop_front());
    end
  end
  initial begin
    exp_t zx, m;
    logic [7:0] ra, rb;
    logic [3:0] ro;
    zx.r = '0; zx.z = 0; zx.c = 0; zx.e = 0;
    #3;
    zx.name = "reset_initial";
    compare(zx);
    @(negedge clk);
    rst = 1'b0;
    issue(8'd200, 8'd100, 4'd0, 8'h2C, 0, 1, 0, "add_200_100");
    issue(8'd255, 8'd1,   4'd0, 8'h00, 1, 1, 0, "add_wrap_zero");
    issue(8'd5,   8'd7,   4'd1, 8'hFE, 0, 1, 0, "sub_5_7");
    issue(8'd9,   8'd9,   4'd1, 8'h00, 1, 0, 0, "sub_9_9");
    issue(8'hF0,  8'h3C,  4'd2, 8'h30, 0, 0, 0, "and");
    issue(8'hF0,  8'h0F,  4'd3, 8'hFF, 0, 0, 0, "or");
    issue(8'hFF,  8'h0F,  4'd4, 8'hF0, 0, 0, 0, "xor");
    issue(8'h0F,  8'hAA,  4'd5, 8'hF0, 0, 0, 0, "not");
    issue(8'h81,  8'h01,  4'd6, 8'h02, 0, 1, 0, "shl_1");
    issue(8'h81,  8'h01,  4'd7, 8'h40, 0, 1, 0, "shr_1");
    issue(8'h81,  8'h01,  4'd8, 8'hC0, 0, 1, 0, "sra_1");
    issue(8'h81,  8'h01,  4'd10, 8'hC0, 0, 0, 0, "ror_1");
    issue(8'h81,  8'h01,  4'd9, 8'h03, 0, 0, 0, "rol_1");
    issue(8'h81,  8'h09,  4'd6, 8'h02, 0, 1, 0, "shl_b9");
    issue(8'h81,  8'h00,  4'd6, 8'h81, 0, 0, 0, "shl_0");
    issue(8'h01,  8'h07,  4'd6, 8'h80, 0, 0, 0, "shl_7");
    issue(8'h80,  8'h07,  4'd7, 8'h01, 0, 0, 0, "shr_7");
    issue(8'h80,  8'h07,  4'd8, 8'hFF, 0, 0, 0, "sra_7");
    issue(8'd16,  8'd16,  4'd11, 8'h00, 1, 1, 0, "mul_16_16");
    issue(8'd15,  8'd17,  4'd11, 8'hFF, 0, 0, 0, "mul_15_17");
    issue(8'd100, 8'd7,   4'd12, 8'd14, 0, 0, 0, "div_100_7");
    issue(8'd100, 8'd7,   4'd13, 8'd2,  0, 0, 0, "mod_100_7");
    issue(8'd10,  8'd0,   4'd12, 8'h00, 0, 0, 1, "div_by_0");
    issue(8'd10,  8'd0,   4'd13, 8'h00, 0, 0, 1, "mod_by_0");
    issue(8'h12,  8'h34,  4'd14, 8'h00, 0, 0, 1, "op14");
    issue(8'h00,  8'h00,  4'd15, 8'h00, 0, 0, 1, "op15");
    issue(8'hF0,  8'h3C,  4'd2, 8'h30, 0, 0, 0, "and_after_err");
    issue(8'd200, 8'd100, 4'd0, 8'h2C, 0, 1, 0, "add_before_reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    zx.name = "reset_async";
    compare(zx);
    @(posedge clk);
    #1;
    zx.name = "reset_held";
    compare(zx);
    @(negedge clk);
    rst = 1'b0;
    issue(8'd3, 8'd4, 4'd0, 8'd7, 0, 0, 0, "add_3_4_after_reset");
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 4'($urandom_range(0, 15));
      m = model(ra, rb, ro);
      issue(ra, rb, ro, m.r, m.z, m.c, m.e, m.name);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
